// File: rtl/inst_fetch_queue.sv
// Fetches from a combinational ROM into a prefetch FIFO. A word pushed on one edge reaches the head after that edge; a redirect reaches the head after 2 edges.
// Fetch stalls (rom_addr holds) while the FIFO is full and the head is not being popped; a redirect flushes the FIFO and restarts fetch.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     rom_ce,
    output logic [31:0]              rom_addr,
    input  logic [31:0]              rom_inst,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_pc,
    output logic [31:0]              id_inst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    state_t          state;
    state_t          state_nxt;
    logic [31:0]     fetch_pc;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    entry_t          mem [DEPTH];
    entry_t          head;
    logic            push;
    logic            pop;
    logic [1:0]      unused_redirect_bits;

    assign unused_redirect_bits = redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rom_ce = (state == RUN);
    end

    assign rom_addr = fetch_pc;
    assign id_valid = (count != '0);

    // Redirect blocks both sides so the word fetched this cycle (old stream) is dropped.
    assign pop  = id_valid & id_ready & ~redirect;
    assign push = rom_ce & ~redirect & ((count != FULL_CNT) | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: fetch_pc, inst: rom_inst};
        end
    end

    assign head    = mem[rd_ptr];
    assign id_pc   = id_valid ? head.pc   : 32'h0;
    assign id_inst = id_valid ? head.inst : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed vector bench for inst_fetch_queue: start-up, backpressure, full pop/push, redirect, wrap, mid-stream reset.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_ce      (rom_ce),
        .rom_addr    (rom_addr),
        .rom_inst    (rom_inst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_inst     (id_inst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word k holds 32'h1000_0000 + k
    assign rom_inst = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

    typedef struct {
        logic        ready;
        logic        redir;
        logic [31:0] rpc;
        logic        e_ce;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic [31:0] e_addr;
    } vec_t;

    vec_t startup_tbl[$];
    vec_t main_tbl[$];

    function automatic vec_t mk(logic ready, logic redir, logic [31:0] rpc, logic e_ce,
                                logic e_valid, logic [31:0] e_pc, logic [2:0] e_cnt,
                                logic [31:0] e_addr);
        vec_t v;
        v.ready = ready; v.redir = redir; v.rpc = rpc; v.e_ce = e_ce;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_reset(string tag);
        chk({tag, ".rom_ce"},   {31'b0, rom_ce},   32'h0);
        chk({tag, ".rom_addr"}, rom_addr,          32'h0);
        chk({tag, ".count"},    {29'b0, count},    32'h0);
        chk({tag, ".id_valid"}, {31'b0, id_valid}, 32'h0);
        chk({tag, ".id_pc"},    id_pc,             32'h0);
        chk({tag, ".id_inst"},  id_inst,           32'h0);
    endtask

    task automatic apply(vec_t v, string tag);
        logic [31:0] e_inst;
        id_ready    = v.ready;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        @(posedge clk);
        #1;
        e_inst = v.e_valid ? 32'h1000_0000 + {2'b00, v.e_pc[31:2]} : 32'h0;
        chk({tag, ".rom_ce"},   {31'b0, rom_ce},   {31'b0, v.e_ce});
        chk({tag, ".id_valid"}, {31'b0, id_valid}, {31'b0, v.e_valid});
        chk({tag, ".id_pc"},    id_pc,             v.e_valid ? v.e_pc : 32'h0);
        chk({tag, ".id_inst"},  id_inst,           e_inst);
        chk({tag, ".count"},    {29'b0, count},    {29'b0, v.e_cnt});
        chk({tag, ".rom_addr"}, rom_addr,          v.e_addr);
    endtask

    initial begin
        //                      rdy rd  rpc            ce val pc             cnt addr
        startup_tbl.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          0, 32'h0));
        startup_tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'h0,          1, 32'h4));
        startup_tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'h4,          1, 32'h8));
        startup_tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'h8,          1, 32'hC));

        // restart at 0 then fill under backpressure
        main_tbl.push_back(mk(0, 1, 32'h0,             1, 0, 32'h0,          0, 32'h0));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h0,          1, 32'h4));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h0,          2, 32'h8));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h0,          3, 32'hC));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h0,          4, 32'h10));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h0,          4, 32'h10));
        // full: simultaneous pop/push, then drain in order
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'h4,          4, 32'h14));
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'h8,          4, 32'h18));
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'hC,          4, 32'h1C));
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'h10,         4, 32'h20));
        // build count=3 at 0x200, then redirect to 0x103 (ready high but pop blocked)
        main_tbl.push_back(mk(0, 1, 32'h200,           1, 0, 32'h0,          0, 32'h200));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h200,        1, 32'h204));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h200,        2, 32'h208));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h200,        3, 32'h20C));
        main_tbl.push_back(mk(1, 1, 32'h103,           1, 0, 32'h0,          0, 32'h100));
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h100,        1, 32'h104));
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'h104,        1, 32'h108));
        // address wrap
        main_tbl.push_back(mk(1, 1, 32'hFFFF_FFF8,     1, 0, 32'h0,          0, 32'hFFFF_FFF8));
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'hFFFF_FFF8,  1, 32'hFFFF_FFFC));
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'hFFFF_FFFC,  1, 32'h0));
        main_tbl.push_back(mk(1, 0, 32'h0,             1, 1, 32'h0,          1, 32'h4));
        // leave two entries pending for the mid-stream reset
        main_tbl.push_back(mk(0, 0, 32'h0,             1, 1, 32'h0,          2, 32'h8));

        rst         = 1'b1;
        id_ready    = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        #2 rst = 1'b0;
        #1 chk_reset("async_reset");
        repeat (2) @(posedge clk);
        #1 chk_reset("held_reset");
        rst = 1'b1;

        for (int i = 0; i < startup_tbl.size(); i++)
            apply(startup_tbl[i], $sformatf("startup[%0d]", i));
        for (int i = 0; i < main_tbl.size(); i++)
            apply(main_tbl[i], $sformatf("main[%0d]", i));

        // mid-stream reset between edges: clears without a clock edge
        id_ready = 1'b1;
        #2 rst = 1'b0;
        #1 chk_reset("mid_reset");
        @(posedge clk);
        #1 chk_reset("mid_reset_edge");
        rst = 1'b1;
        for (int i = 0; i < startup_tbl.size(); i++)
            apply(startup_tbl[i], $sformatf("restart[%0d]", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Instruction-fetch initiator for the instruction ROM port. It generates the fetch PC and drives `rom_ce`/`rom_addr`. The ROM answers combinationally within the same cycle, and the block captures the returned word together with its PC into a small prefetch FIFO. The decode stage drains that FIFO through a valid/ready handshake, and a branch/exception redirect flushes the FIFO and restarts fetch.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥ 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; word-aligned.

Ports:
- `clk`  in  1  system clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `rom_ce`  out  1  ROM chip enable; 1 = enabled.
- `rom_addr`  out  32  byte address of the word being fetched; bits [1:0] always 0.
- `rom_inst`  in  32  ROM data for `rom_addr`; valid in the same cycle while `rom_ce`=1.
- `id_valid`  out  1  FIFO head holds an instruction.
- `id_ready`  in  1  decode stage accepts the head this cycle.
- `id_pc`  out  32  PC of the head entry; 0 when `id_valid`=0.
- `id_inst`  out  32  instruction of the head entry; 0 when `id_valid`=0.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- `count`  out  log2(DEPTH)+1  current number of FIFO entries.

## Operation
States:
- **IDLE** (during reset, `rom_ce`=0).
- **RUN**: entered on the first rising edge after `rst` deasserts. Registered `rom_ce` is 1 from then on and is never deasserted except by reset.

Internal `fetch_pc` register:
- `rom_addr` = `fetch_pc` in every state.

Push:
- Occurs on an edge where state is RUN, `redirect`=0, and (`count` < DEPTH or pop occurs).
- Writes {`fetch_pc`, `rom_inst`} at the tail.
- `fetch_pc` += 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- With no push, `fetch_pc` holds and `rom_addr` stays stable.

Pop:
- Occurs on an edge where `id_valid`=1, `id_ready`=1 and `redirect`=0.
- Removes the head entry.

Redirect, which has priority over everything:
- Clears `count` to 0.
- Sets `fetch_pc` to {`redirect_pc`[31:2], 2'b00}.
- Blocks push and pop for that cycle.
- The ROM word returned during a redirect cycle is discarded.

Other rules:
- Simultaneous push and pop when full: both occur and `count` stays at DEPTH.
- Empty FIFO: there is no bypass. A word pushed on edge N is first visible at the head after edge N.
- Pointers are log2(DEPTH) bits and wrap naturally. `count` = push − pop, and never exceeds DEPTH or underflows.
- `id_pc` and `id_inst` are taken combinationally from the head entry and are forced to 0 when the FIFO is empty.

## Timing
- While `rst`=0, asynchronously:
  - `rom_ce`=0, `rom_addr`=`RESET_PC`
  - `count`=0, `id_valid`=0, `id_pc`=0, `id_inst`=0
  - state IDLE
- Edge 1 after release: state RUN and `rom_ce`=1. No push, because `rom_ce` was 0 during the cycle before the edge.
- Edge 2: first push (PC = `RESET_PC`). `id_valid`=1 after edge 2.
- Steady state with `id_ready`=1 held: one push and one pop per cycle, and `id_pc` advances by 4 every cycle.
- Redirect asserted in cycle N:
  - After edge N: `count`=0, `id_valid`=0, `rom_addr`=new PC.
  - Edge N+1 pushes the new PC; `id_valid`=1 after edge N+1.
  - Redirect-to-head latency is 2 edges.
- Reset asserted mid-operation: all state clears immediately without waiting for a clock edge. Restart follows the post-reset sequence above.

## Test plan
- **Reset start-up.** `RESET_PC`=0, ROM word k = 32'h1000_0000+k, `id_ready`=1, release reset.
  - `rom_ce` rises at edge 1.
  - `id_valid` rises at edge 2 with `id_pc`=0 and `id_inst`=32'h1000_0000.
  - `id_pc` then reads 4, 8, … on consecutive cycles.
- **Backpressure fill.** Hold `id_ready`=0 after start-up.
  - `count` rises to 4 and stops; `rom_addr` holds 32'h10.
  - Head stays at `id_pc`=0.
  - Release `id_ready`: entries drain in order 0, 4, 8, C, 10.
- **Full with simultaneous pop/push.** With `count`=4, assert `id_ready` for 1 cycle.
  - `count` stays 4, `rom_addr` advances 32'h10 → 32'h14.
  - Head becomes PC 4.
- **Redirect with pending entries.** `count`=3, pulse `redirect` with `redirect_pc`=32'h103.
  - Next cycle: `count`=0, `id_valid`=0, `rom_addr`=32'h100.
  - Following cycle: `id_pc`=32'h100.
  - Old entries never appear at the head.
- **Address wrap.** Redirect to 32'hFFFF_FFF8 with `id_ready`=1.
  - `id_pc` sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Reset mid-stream.** Assert `rst`=0 with `count`=2 between clock edges.
  - Outputs clear immediately: `id_valid`=0, `rom_ce`=0, `rom_addr`=`RESET_PC`.
  - After release, the start-up sequence repeats exactly.
